seq_addsub: RTL and testbench

- Parametrised, multi-cycle registered adder/subtractor; successor to the 4-bit single-cycle registered adder.
- Processes operands CHUNK bits per clock, so wide datapaths avoid a long carry chain.
- Supports add/sub, signed/unsigned overflow detection and a start/ready/done handshake.
- Sits beside the ALU as the wide arithmetic unit for multi-word operations.

---
 rtl/seq_addsub.sv | 158 +++++++++++++++
 tb/tb_seq_addsub.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// Purpose: multi-cycle registered add/sub, CHUNK bits per cycle, carry/overflow flags; SEQ_ADDSUB_SAT_EN adds saturation.
// Latency: Done pulses N = WIDTH/CHUNK cycles after the accepting Start edge; throughput one op per N+1 cycles.
// Backpressure: Start is taken only while Ready=1; requests seen while busy are dropped, not queued.
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  // Control strobes decoded from the FSM
  logic load;   // accept a new operation this edge
  logic step;   // process one chunk this edge
  logic last;   // this edge processes the final chunk

  // Operand shift registers: the active chunk always sits in the low CHUNK bits
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;     // holds B, or ~B for subtraction
  logic [WIDTH-1:0] res_q;    // result fills in from the top, chunk by chunk
  logic             c_q;      // carry between chunks
  logic [CW-1:0]    cnt_q;
  logic             sub_q;
  logic             sgn_q;
`ifdef SEQ_ADDSUB_SAT_EN
  logic             a_msb_q;  // sign of A picks the signed clamp direction
`endif

  // Per-chunk datapath
  logic [CHUNK:0]   csum;
  logic             cout;
  logic             cmsb;
  logic [WIDTH-1:0] res_nxt;
  logic             ovf_nxt;
  logic [WIDTH-1:0] sum_nxt;

  assign Ready = (state_q == IDLE);

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Chunk adder, final-result assembly, overflow rule and optional clamp
  always_comb begin
    csum    = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + (CHUNK+1)'(c_q);
    cout    = csum[CHUNK];
    // Carry into the top bit recovered from the sum bit: s = a ^ b ^ cin.
    cmsb    = a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ csum[CHUNK-1];
    res_nxt = (res_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
    // Unsigned sub overflows on borrow, i.e. when the inverted-add carry is 0.
    ovf_nxt = sgn_q ? (cmsb ^ cout) : (sub_q ? ~cout : cout);
    sum_nxt = res_nxt;
`ifdef SEQ_ADDSUB_SAT_EN
    if (ovf_nxt) begin
      if (!sgn_q)
        sum_nxt = sub_q ? '0 : '1;
      else if (a_msb_q)
        sum_nxt = {1'b1, {(WIDTH-1){1'b0}}};
      else
        sum_nxt = {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Operand capture and chunk-by-chunk accumulation
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      sgn_q   <= 1'b0;
`ifdef SEQ_ADDSUB_SAT_EN
      a_msb_q <= 1'b0;
`endif
    end else if (load) begin
      a_sh    <= A;
      b_sh    <= Sub ? ~B : B;
      res_q   <= '0;
      c_q     <= Sub;          // +1 completes the two's-complement negate
      cnt_q   <= '0;
      sub_q   <= Sub;
      sgn_q   <= Signed;
`ifdef SEQ_ADDSUB_SAT_EN
      a_msb_q <= A[WIDTH-1];
`endif
    end else if (step) begin
      a_sh    <= a_sh >> CHUNK;
      b_sh    <= b_sh >> CHUNK;
      res_q   <= res_nxt;
      c_q     <= cout;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Architectural outputs: only updated on the completing edge
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Done     <= 1'b0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Done <= last;
      if (last) begin
        Sum      <= sum_nxt;
        Carry    <= cout;
        Overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub: 8-bit/4-bit-chunk instance for arithmetic and handshake,
// 32-bit/8-bit-chunk instance for the reset-abort case.
// Expected values are hand-computed; saturated values are selected when SEQ_ADDSUB_SAT_EN is defined.
module tb_seq_addsub;

`ifdef SEQ_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  // 8-bit instance
  logic       rst_n, start, sub, sgn;
  logic [7:0] a, b;
  logic       ready, done, carry, ovf;
  logic [7:0] sum;

  // 32-bit instance
  logic        w_rst_n, w_start, w_sub, w_sgn;
  logic [31:0] w_a, w_b;
  logic        w_ready, w_done, w_carry, w_ovf;
  logic [31:0] w_sum;

  int n_chk = 0;
  int n_err = 0;
  int lat;

  seq_addsub #(.WIDTH(8), .CHUNK(4)) dut (
    .Clk(Clk), .Rst_n(rst_n), .Start(start), .Sub(sub), .Signed(sgn),
    .A(a), .B(b), .Ready(ready), .Done(done), .Sum(sum),
    .Carry(carry), .Overflow(ovf)
  );

  seq_addsub #(.WIDTH(32), .CHUNK(8)) dut32 (
    .Clk(Clk), .Rst_n(w_rst_n), .Start(w_start), .Sub(w_sub), .Signed(w_sgn),
    .A(w_a), .B(w_b), .Ready(w_ready), .Done(w_done), .Sum(w_sum),
    .Carry(w_carry), .Overflow(w_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation: fixed latency of 2 cycles, then a hold check.
  task automatic op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                     input logic isub, input logic isgn,
                     input logic [7:0] es, input logic ec, input logic eo);
    a = ia; b = ib; sub = isub; sgn = isgn; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0; a = 8'hA5; b = 8'h5A; sub = ~isub; sgn = ~isgn;
    chk({tag, ".rdy_t0"}, 32'(ready), 32'd0);
    @(posedge Clk); #1;
    chk({tag, ".done_t1"}, 32'(done), 32'd0);
    chk({tag, ".rdy_t1"}, 32'(ready), 32'd0);
    @(posedge Clk); #1;
    chk({tag, ".done_t2"}, 32'(done), 32'd1);
    chk({tag, ".rdy_t2"}, 32'(ready), 32'd1);
    chk({tag, ".sum"}, 32'(sum), 32'(es));
    chk({tag, ".carry"}, 32'(carry), 32'(ec));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    @(posedge Clk); #1;
    chk({tag, ".done_off"}, 32'(done), 32'd0);
    chk({tag, ".sum_hold"}, 32'(sum), 32'(es));
  endtask

  // Bounded wait for Done on the 32-bit instance; lat = -1 if it never comes.
  task automatic wait32(output int l);
    l = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clk); #1;
      if (w_done) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; sgn = 1'b0; a = '0; b = '0;
    w_rst_n = 1'b0; w_start = 1'b0; w_sub = 1'b0; w_sgn = 1'b0; w_a = '0; w_b = '0;
    #12;
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.carry", 32'(carry), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    chk("rst.w_ready", 32'(w_ready), 32'd1);
    @(posedge Clk); #1;
    rst_n = 1'b1; w_rst_n = 1'b1;

    op8("uadd",    8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0);
    op8("uadd_ov", 8'hF0, 8'h20, 1'b0, 1'b0, SAT ? 8'hFF : 8'h10, 1'b1, 1'b1);
    op8("sadd_ov", 8'h70, 8'h20, 1'b0, 1'b1, SAT ? 8'h7F : 8'h90, 1'b0, 1'b1);
    op8("sadd_ok", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    op8("usub_ov", 8'h05, 8'h07, 1'b1, 1'b0, SAT ? 8'h00 : 8'hFE, 1'b0, 1'b1);
    op8("ssub_ov", 8'h80, 8'h01, 1'b1, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1);
    op8("sub_zero", 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Start held through RUN with changing operands, then re-accepted in the Done cycle.
    a = 8'h11; b = 8'h22; sub = 1'b0; sgn = 1'b0; start = 1'b1;
    @(posedge Clk); #1;
    chk("b2b.rdy_t0", 32'(ready), 32'd0);
    a = 8'h55; b = 8'h55;
    @(posedge Clk); #1;
    chk("b2b.done_t1", 32'(done), 32'd0);
    @(posedge Clk); #1;
    chk("b2b.done_t2", 32'(done), 32'd1);
    chk("b2b.sum1", 32'(sum), 32'h33);
    chk("b2b.rdy_t2", 32'(ready), 32'd1);
    @(posedge Clk); #1;
    start = 1'b0;
    chk("b2b.rdy_t3", 32'(ready), 32'd0);
    chk("b2b.done_t3", 32'(done), 32'd0);
    chk("b2b.hold_t3", 32'(sum), 32'h33);
    @(posedge Clk); #1;
    chk("b2b.hold_t4", 32'(sum), 32'h33);
    chk("b2b.done_t4", 32'(done), 32'd0);
    @(posedge Clk); #1;
    chk("b2b.done_t5", 32'(done), 32'd1);
    chk("b2b.sum2", 32'(sum), 32'hAA);
    chk("b2b.ovf2", 32'(ovf), 32'd0);

    // 32-bit instance: normal op, then reset mid-RUN, then wrap-around add.
    w_a = 32'h12345678; w_b = 32'h11111111; w_start = 1'b1;
    @(posedge Clk); #1;
    w_start = 1'b0;
    wait32(lat);
    chk("w.lat1", 32'(lat), 32'd4);
    chk("w.sum1", w_sum, 32'h23456789);

    w_a = 32'h0000DEAD; w_b = 32'h00000001; w_start = 1'b1;
    @(posedge Clk); #1;
    w_start = 1'b0;
    @(posedge Clk); #1;
    w_rst_n = 1'b0;
    #1;
    chk("w.abort_sum", w_sum, 32'd0);
    chk("w.abort_carry", 32'(w_carry), 32'd0);
    chk("w.abort_ovf", 32'(w_ovf), 32'd0);
    chk("w.abort_ready", 32'(w_ready), 32'd1);
    chk("w.abort_done", 32'(w_done), 32'd0);
    @(posedge Clk); #1;
    w_rst_n = 1'b1;
    wait32(lat);
    chk("w.no_done", 32'(lat), 32'hFFFFFFFF);

    w_a = 32'hFFFFFFFF; w_b = 32'h00000001; w_start = 1'b1;
    @(posedge Clk); #1;
    w_start = 1'b0;
    wait32(lat);
    chk("w.lat2", 32'(lat), 32'd4);
    chk("w.sum2", w_sum, SAT ? 32'hFFFFFFFF : 32'h00000000);
    chk("w.carry2", 32'(w_carry), 32'd1);
    chk("w.ovf2", 32'(w_ovf), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
